// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and width helpers for the multi-port register file.
package regfile_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_NUM_REGS = 16;
  localparam logic [31:0] DEF_WR_MASK = {16'h3000, 16'hCFFF};
  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  // err_port carries a plain binary port index, one bit wider than strictly needed
  function automatic int err_port_w(input int nw);
    return $clog2(nw) + 1;
  endfunction
endpackage

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: per-register write arbitration (legality, highest-port winner, illegal-write detect).
module regfile_wr_arb import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W = addr_w(NUM_REGS),
  parameter int NUM_WR = 2,
  parameter logic [NUM_WR*NUM_REGS-1:0] WR_MASK = DEF_WR_MASK
) (
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]      wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]      wr_data,
  output logic [NUM_REGS-1:0]           reg_we,
  output logic [NUM_REGS*DATA_W-1:0]    reg_wdata,
  output logic [NUM_WR-1:0]             illegal,
  output logic [err_port_w(NUM_WR)-1:0] first_bad
);
  localparam int EPW = err_port_w(NUM_WR);
  logic [NUM_WR-1:0] legal;
  for (genvar p = 0; p < NUM_WR; p++) begin : g_port
    localparam logic [NUM_REGS-1:0] PMASK = WR_MASK[p*NUM_REGS +: NUM_REGS];
    logic [ADDR_W-1:0] a;
    logic in_rng;
    assign a = wr_addr[p*ADDR_W +: ADDR_W];
    assign in_rng = int'(a) < NUM_REGS;
    assign legal[p] = wr_en[p] && in_rng && PMASK[a];
    assign illegal[p] = wr_en[p] && !legal[p];
  end
  always_comb begin
    reg_we = '0;
    reg_wdata = '0;
    first_bad = '0;
    for (int p = NUM_WR - 1; p >= 0; p--)
      if (illegal[p]) first_bad = EPW'(p);
    // ascending scan so the highest legal port overrides lower ones
    for (int r = 0; r < NUM_REGS; r++)
      for (int p = 0; p < NUM_WR; p++)
        if (legal[p] && wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
          reg_we[r] = 1'b1;
          reg_wdata[r*DATA_W +: DATA_W] = wr_data[p*DATA_W +: DATA_W];
        end
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with per-port write masks, busy scoreboard and sticky illegal-write flag.
// Define REGFILE_BYPASS_EN for write-first reads; otherwise reads return pre-edge state.
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W = addr_w(NUM_REGS),
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter logic [NUM_WR*NUM_REGS-1:0] WR_MASK = DEF_WR_MASK
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_RD*ADDR_W-1:0]      rd_addr,
  output logic [NUM_RD*DATA_W-1:0]      rd_data,
  output logic [NUM_RD-1:0]             rd_busy,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]      wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]      wr_data,
  input  logic                          rsv_en,
  input  logic [ADDR_W-1:0]             rsv_addr,
  output logic                          wr_err,
  output logic [err_port_w(NUM_WR)-1:0] err_port
);
  localparam int EPW = err_port_w(NUM_WR);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic err_q, err_d;
  logic [EPW-1:0] err_port_q, err_port_d;
  logic [NUM_REGS-1:0] reg_we;
  logic [NUM_REGS*DATA_W-1:0] reg_wdata;
  logic [NUM_WR-1:0] illegal;
  logic [EPW-1:0] first_bad;
  regfile_wr_arb #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR), .WR_MASK(WR_MASK)
  ) u_arb (
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .reg_we(reg_we), .reg_wdata(reg_wdata), .illegal(illegal), .first_bad(first_bad)
  );
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (reg_we[r]) regs_d[r] = reg_wdata[r*DATA_W +: DATA_W];
      // a same-cycle reservation names a new producer, so it beats the clearing write
      busy_d[r] = (rsv_en && rsv_addr == ADDR_W'(r)) ? 1'b1 : reg_we[r] ? 1'b0 : busy_q[r];
    end
    err_d = err_q || (|illegal);
    err_port_d = (!err_q && |illegal) ? first_bad : err_port_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      err_q <= 1'b0;
      err_port_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      err_q <= err_d;
      err_port_q <= err_port_d;
    end
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic in_rng;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];
    assign in_rng = int'(a) < NUM_REGS;
`ifdef REGFILE_BYPASS_EN
    assign rd_data[i*DATA_W +: DATA_W] = !in_rng ? '0 :
      reg_we[a] ? reg_wdata[int'(a)*DATA_W +: DATA_W] : regs_q[a];
`else
    assign rd_data[i*DATA_W +: DATA_W] = in_rng ? regs_q[a] : '0;
`endif
    assign rd_busy[i] = in_rng && busy_q[a];
  end
  assign wr_err = err_q;
  assign err_port = err_port_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against a spec-level model.
module tb_regfile_mp;
  localparam logic [31:0] MASK_A = {16'h3000, 16'hCFFF};
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] a_rd_addr, a_wr_addr, b_rd_addr, b_wr_addr;
  logic [31:0] a_rd_data, a_wr_data, b_rd_data, b_wr_data;
  logic [1:0] a_rd_busy, a_wr_en, b_rd_busy, b_wr_en, a_err_port, b_err_port;
  logic a_rsv_en, b_rsv_en, a_wr_err, b_wr_err;
  logic [3:0] a_rsv_addr, b_rsv_addr;
  int n_tests = 0, n_fail = 0;
  logic [15:0] m_reg [16];
  bit m_busy [16];
  bit m_err;
  int m_eport;

  regfile_mp u_a (
    .clk(clk), .reset(reset), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .rsv_en(a_rsv_en),
    .rsv_addr(a_rsv_addr), .wr_err(a_wr_err), .err_port(a_err_port)
  );
  regfile_mp #(.NUM_REGS(12), .WR_MASK(24'hFFFFFF)) u_b (
    .clk(clk), .reset(reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .rsv_en(b_rsv_en),
    .rsv_addr(b_rsv_addr), .wr_err(b_wr_err), .err_port(b_err_port)
  );

  task automatic idle();
    a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0; a_rsv_en = 0; a_rsv_addr = 0;
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_rsv_en = 0; b_rsv_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
    for (int r = 0; r < 16; r++) begin m_reg[r] = 0; m_busy[r] = 0; end
    m_err = 0; m_eport = 0;
  endtask

  function automatic bit legal_a(input int p);
    int ad = int'(a_wr_addr[p*4 +: 4]);
    return a_wr_en[p] && MASK_A[p*16 + ad];
  endfunction

  function automatic logic [15:0] exp_rd_a(input logic [3:0] ad);
    logic [15:0] v = m_reg[ad];
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < 2; p++)
      if (legal_a(p) && a_wr_addr[p*4 +: 4] == ad) v = a_wr_data[p*16 +: 16];
`endif
    return v;
  endfunction

  task automatic model_commit_a();
    bit first = 1;
    for (int p = 0; p < 2; p++) begin
      if (legal_a(p)) begin
        m_reg[a_wr_addr[p*4 +: 4]] = a_wr_data[p*16 +: 16];
        m_busy[a_wr_addr[p*4 +: 4]] = 0;
      end else if (a_wr_en[p]) begin
        if (!m_err && first) m_eport = p;
        first = 0;
      end
    end
    if (!first) m_err = 1;
    if (a_rsv_en) m_busy[a_rsv_addr] = 1;
  endtask

  task automatic test_reset();
    idle();
    a_rd_addr = {4'd5, 4'd3}; b_rd_addr = {4'd11, 4'd0};
    repeat (2) tick();
    reset = 0;
    #1;
    n_tests++; if (a_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd got %h exp 0", a_rd_data); end
    n_tests++; if ({a_wr_err, a_err_port, a_rd_busy} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0", {a_wr_err, a_err_port, a_rd_busy}); end
    a_wr_en = 2'b01; a_wr_addr = 8'h03; a_wr_data = 32'h0000_1111;
    tick();
    n_tests++; if (a_rd_data[15:0] !== 16'h1111) begin n_fail++; $display("FAIL pre_write got %h exp 1111", a_rd_data[15:0]); end
    a_wr_data = 32'h0000_BEEF; a_rsv_en = 1; a_rsv_addr = 3;
    reset = 1;
    tick();
    idle();
    reset = 0;
    #1;
    n_tests++; if (a_rd_data[15:0] !== 16'h0) begin n_fail++; $display("FAIL reset_mid_write got %h exp 0", a_rd_data[15:0]); end
    n_tests++; if (a_rd_busy[0] !== 1'b0 || a_wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_mid_flags busy %b err %b exp 0 0", a_rd_busy[0], a_wr_err); end
  endtask

  task automatic test_masks();
    do_reset();
    a_rd_addr = {4'd0, 4'd12};
    a_wr_en = 2'b01; a_wr_addr = 8'h0C; a_wr_data = 32'h0000_1234;
    tick();
    idle();
    #1;
    n_tests++; if (a_wr_err !== 1'b1 || a_err_port !== 2'd0) begin n_fail++; $display("FAIL mask_err err %b port %0d exp 1 0", a_wr_err, a_err_port); end
    n_tests++; if (a_rd_data[15:0] !== 16'h0) begin n_fail++; $display("FAIL mask_drop got %h exp 0", a_rd_data[15:0]); end
    a_wr_en = 2'b10; a_wr_addr = 8'hC0; a_wr_data = 32'h5678_0000;
    tick();
    idle();
    #1;
    n_tests++; if (a_rd_data[15:0] !== 16'h5678) begin n_fail++; $display("FAIL mask_port1 got %h exp 5678", a_rd_data[15:0]); end
    do_reset();
    a_wr_en = 2'b10; a_wr_addr = 8'h00; a_wr_data = 32'hFFFF_0000;
    tick();
    a_wr_en = 2'b01; a_wr_addr = 8'h0D;
    tick();
    idle();
    #1;
    n_tests++; if (a_wr_err !== 1'b1 || a_err_port !== 2'd1) begin n_fail++; $display("FAIL err_first_latched err %b port %0d exp 1 1", a_wr_err, a_err_port); end
    n_tests++; if (a_rd_data[31:16] !== 16'h0) begin n_fail++; $display("FAIL mask_drop_p1 got %h exp 0", a_rd_data[31:16]); end
    do_reset();
    a_wr_en = 2'b11; a_wr_addr = 8'h0C;
    tick();
    idle();
    #1;
    n_tests++; if (a_err_port !== 2'd0) begin n_fail++; $display("FAIL err_lowest got %0d exp 0", a_err_port); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    a_rd_addr = {4'd0, 4'd7};
    a_rsv_en = 1; a_rsv_addr = 7;
    #1;
    n_tests++; if (a_rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL busy_no_bypass got %b exp 0", a_rd_busy[0]); end
    tick();
    idle();
    #1;
    n_tests++; if (a_rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL busy_set got %b exp 1", a_rd_busy[0]); end
    a_wr_en = 2'b01; a_wr_addr = 8'h07; a_wr_data = 32'h0000_0777;
    tick();
    idle();
    #1;
    n_tests++; if (a_rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL busy_clear got %b exp 0", a_rd_busy[0]); end
    a_wr_en = 2'b01; a_wr_addr = 8'h07; a_wr_data = 32'h0000_0999; a_rsv_en = 1; a_rsv_addr = 7;
    tick();
    idle();
    #1;
    n_tests++; if (a_rd_busy[0] !== 1'b1 || a_rd_data[15:0] !== 16'h0999) begin n_fail++; $display("FAIL rsv_wins busy %b data %h exp 1 0999", a_rd_busy[0], a_rd_data[15:0]); end
  endtask

  task automatic test_bypass();
    do_reset();
    a_rd_addr = {4'd0, 4'd2};
    a_wr_en = 2'b01; a_wr_addr = 8'h02; a_wr_data = 32'h0000_0011;
    tick();
    a_wr_data = 32'h0000_00AA;
    #1;
`ifdef REGFILE_BYPASS_EN
    n_tests++; if (a_rd_data[15:0] !== 16'h00AA) begin n_fail++; $display("FAIL bypass got %h exp 00aa", a_rd_data[15:0]); end
`else
    n_tests++; if (a_rd_data[15:0] !== 16'h0011) begin n_fail++; $display("FAIL no_bypass got %h exp 0011", a_rd_data[15:0]); end
`endif
    tick();
    idle();
    #1;
    n_tests++; if (a_rd_data[15:0] !== 16'h00AA) begin n_fail++; $display("FAIL bypass_commit got %h exp 00aa", a_rd_data[15:0]); end
  endtask

  task automatic test_collision();
    do_reset();
    b_rd_addr = {4'd2, 4'd5};
    b_wr_en = 2'b11; b_wr_addr = 8'h55; b_wr_data = 32'hBBBB_AAAA;
    #1;
`ifdef REGFILE_BYPASS_EN
    n_tests++; if (b_rd_data[15:0] !== 16'hBBBB) begin n_fail++; $display("FAIL coll_bypass got %h exp bbbb", b_rd_data[15:0]); end
`else
    n_tests++; if (b_rd_data[15:0] !== 16'h0) begin n_fail++; $display("FAIL coll_pre got %h exp 0", b_rd_data[15:0]); end
`endif
    tick();
    b_wr_addr = 8'h21; b_wr_data = 32'h2222_1111;
    #1;
    n_tests++; if (b_rd_data[15:0] !== 16'hBBBB) begin n_fail++; $display("FAIL collision got %h exp bbbb", b_rd_data[15:0]); end
    tick();
    idle();
    b_rd_addr = {4'd2, 4'd1};
    #1;
    n_tests++; if (b_rd_data !== 32'h2222_1111) begin n_fail++; $display("FAIL dual_commit got %h exp 22221111", b_rd_data); end
  endtask

  task automatic test_range();
    do_reset();
    b_rd_addr = {4'd11, 4'd13};
    b_rsv_en = 1; b_rsv_addr = 13;
    tick();
    idle();
    #1;
    n_tests++; if (b_rd_data[15:0] !== 16'h0 || b_rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL range_rd data %h busy %b exp 0 0", b_rd_data[15:0], b_rd_busy[0]); end
    n_tests++; if (b_wr_err !== 1'b0) begin n_fail++; $display("FAIL range_rsv_err got %b exp 0", b_wr_err); end
    b_wr_en = 2'b11; b_wr_addr = 8'hDB; b_wr_data = 32'h7777_0BBB;
    tick();
    idle();
    #1;
    n_tests++; if (b_wr_err !== 1'b1 || b_err_port !== 2'd1) begin n_fail++; $display("FAIL range_wr_err err %b port %0d exp 1 1", b_wr_err, b_err_port); end
    n_tests++; if (b_rd_data !== 32'h0BBB_0000) begin n_fail++; $display("FAIL range_edge got %h exp 0bbb0000", b_rd_data); end
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c % 100 == 99) do_reset();
      a_wr_en = 2'($urandom); a_wr_addr = 8'($urandom); a_wr_data = $urandom;
      a_rsv_en = ($urandom_range(0, 2) == 0); a_rsv_addr = 4'($urandom);
      a_rd_addr = 8'($urandom);
      #1;
      for (int i = 0; i < 2; i++) begin
        logic [3:0] ad = a_rd_addr[i*4 +: 4];
        n_tests++;
        if (a_rd_data[i*16 +: 16] !== exp_rd_a(ad) || a_rd_busy[i] !== m_busy[ad]) begin
          n_fail++; bad++;
          if (bad < 10) $display("FAIL rand_rd%0d cyc %0d addr %0d data %h busy %b exp %h %b", i, c, ad, a_rd_data[i*16 +: 16], a_rd_busy[i], exp_rd_a(ad), m_busy[ad]);
        end
      end
      @(posedge clk);
      model_commit_a();
      #1;
      n_tests++;
      if (a_wr_err !== m_err || a_err_port !== 2'(m_eport)) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL rand_err cyc %0d err %b port %0d exp %b %0d", c, a_wr_err, a_err_port, m_err, m_eport);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_masks();
    test_scoreboard();
    test_bypass();
    test_collision();
    test_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
